// File: rtl/mux_scan_if.sv
// Bus between the scan sequencer, the 4:1 mux it drives, and the frame consumer.
// master: the sequencer side. slave: the mux/consumer side.
interface mux_scan_if;
  logic       start;
  logic       mux_out;
  logic       address0;
  logic       address1;
  logic [3:0] frame;
  logic       frame_valid;
  logic       frame_ready;
  logic       busy;

  modport master (
    input  start, mux_out, frame_ready,
    output address0, address1, frame, frame_valid, busy
  );

  modport slave (
    output start, mux_out, frame_ready,
    input  address0, address1, frame, frame_valid, busy
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Steps a 4:1 mux through channels 0..3 and waits SETTLE cycles on each one.
// It samples the mux output at the end of each wait and hands the assembled
// 4-bit frame downstream over a valid/ready handshake.
module mux_scan_sequencer #(
  parameter int SETTLE = 2
) (
  input logic        clk,
  input logic        reset,
  mux_scan_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_HOLD
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [1:0] ch_q, ch_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] shadow_q, shadow_d;
  logic [3:0] frame_q, frame_d;
  logic       frame_valid_q, frame_valid_d;

  // The channel register drives the mux select lines directly, so the address is registered.
  assign bus.address0    = ch_q[0];
  assign bus.address1    = ch_q[1];
  assign bus.frame       = frame_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.busy        = (state_q != S_IDLE);

  // State register. Reset discards any partial scan and any unconsumed frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ch_q          <= 2'd0;
      cnt_q         <= 4'd0;
      shadow_q      <= 4'd0;
      frame_q       <= 4'd0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  // Next-state logic: settle countdown, per-channel sampling, frame hand-off.
  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    cnt_d         = cnt_q;
    shadow_d      = shadow_q;
    frame_d       = frame_q;
    frame_valid_d = frame_valid_q;

    unique case (state_q)
      S_IDLE: begin
        ch_d = 2'd0;
        if (bus.start) begin
          state_d = S_SETTLE;
          cnt_d   = 4'd0;
        end
      end

      S_SETTLE: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          shadow_d[ch_q] = bus.mux_out;
          if (ch_q != 2'd3) begin
            ch_d  = ch_q + 2'd1;
            cnt_d = 4'd0;
          end else begin
            // The last channel goes straight into the frame, because shadow[3]
            // only updates on this same edge. A partial scan never reaches frame.
            frame_d       = {bus.mux_out, shadow_q[2:0]};
            frame_valid_d = 1'b1;
            state_d       = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (frame_valid_q && bus.frame_ready) begin
          frame_valid_d = 1'b0;
          ch_d          = 2'd0;
          if (bus.start) begin
            state_d = S_SETTLE;
            cnt_d   = 4'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer with SETTLE=2. A behavioural 4:1 mux
// sits between the stimulus register in_pat and the sequencer.
module tb_mux_scan_sequencer;

  logic       clk;
  logic       reset;
  logic [3:0] in_pat;   // in_pat[k] is mux input in_k

  int checks = 0;
  int fails  = 0;
  int n;

  mux_scan_if bus ();

  mux_scan_sequencer #(.SETTLE(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.mux_out = in_pat[{bus.address1, bus.address0}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a scan with a one-cycle start pulse. Returns 1 ns after the accept edge E0.
  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Count edges after E0 until frame_valid rises. The count is bounded.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!bus.frame_valid && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  // Consume the frame with start low, which returns the sequencer to IDLE.
  task automatic consume();
    bus.frame_ready = 1'b1;
    tick();
    bus.frame_ready = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.start       = 1'b1;
    bus.frame_ready = 1'b0;
    in_pat          = 4'b0000;

    // Reset held for two edges, with start asserted throughout.
    tick();
    tick();
    check("rst_addr",  {6'd0, bus.address1, bus.address0}, 8'd0);
    check("rst_frame", {4'd0, bus.frame}, 8'd0);
    check("rst_valid", {7'd0, bus.frame_valid}, 8'd0);
    check("rst_busy",  {7'd0, bus.busy}, 8'd0);
    reset     = 1'b0;
    bus.start = 1'b0;
    tick();
    check("idle_busy", {7'd0, bus.busy}, 8'd0);

    // Basic scan: in0..in3 = 1,0,1,1 gives frame 4'b1101.
    in_pat = 4'b1101;
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      check($sformatf("seq_addr_%0d", k), {6'd0, bus.address1, bus.address0}, 8'(k / 2));
      check($sformatf("seq_busy_%0d", k), {7'd0, bus.busy}, 8'd1);
      check($sformatf("seq_vld_%0d", k), {7'd0, bus.frame_valid}, 8'd0);
      if (k < 7) tick();
    end
    tick();
    check("basic_valid", {7'd0, bus.frame_valid}, 8'd1);
    check("basic_frame", {4'd0, bus.frame}, 8'hD);
    in_pat = 4'b0000;
    for (int k = 0; k < 3; k++) tick();
    check("hold_valid", {7'd0, bus.frame_valid}, 8'd1);
    check("hold_frame", {4'd0, bus.frame}, 8'hD);
    check("hold_addr",  {6'd0, bus.address1, bus.address0}, 8'd3);
    consume();
    check("done_busy",  {7'd0, bus.busy}, 8'd0);
    check("done_valid", {7'd0, bus.frame_valid}, 8'd0);
    check("done_addr",  {6'd0, bus.address1, bus.address0}, 8'd0);
    check("done_frame", {4'd0, bus.frame}, 8'hD);

    // All 16 input patterns.
    for (int p = 0; p < 16; p++) begin
      in_pat = 4'(p);
      pulse_start();
      wait_valid(n);
      check($sformatf("ex_lat_%0d", p), 8'(n), 8'd8);
      check($sformatf("ex_frame_%0d", p), {4'd0, bus.frame}, 8'(p));
      consume();
    end

    // Back-to-back: handshake together with start, then inputs become 0,1,0,0.
    in_pat = 4'b1010;
    pulse_start();
    wait_valid(n);
    check("b2b_first", {4'd0, bus.frame}, 8'hA);
    bus.frame_ready = 1'b1;
    bus.start       = 1'b1;
    tick();
    bus.frame_ready = 1'b0;
    bus.start       = 1'b0;
    in_pat          = 4'b0010;
    check("b2b_addr",  {6'd0, bus.address1, bus.address0}, 8'd0);
    check("b2b_busy",  {7'd0, bus.busy}, 8'd1);
    n = 0;
    while (!bus.frame_valid && n < 40) begin
      n++;
      tick();
    end
    check("b2b_gap",   8'(n), 8'd8);
    check("b2b_frame", {4'd0, bus.frame}, 8'h2);
    consume();

    // Ignored start: pulse start while channel 2 is selected.
    in_pat = 4'b0110;
    pulse_start();
    for (int k = 0; k < 4; k++) tick();
    check("ign_addr", {6'd0, bus.address1, bus.address0}, 8'd2);
    pulse_start();
    n = 5;
    while (!bus.frame_valid && n < 40) begin
      tick();
      n++;
    end
    check("ign_lat",   8'(n), 8'd8);
    check("ign_frame", {4'd0, bus.frame}, 8'h6);
    consume();
    n = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.busy || bus.frame_valid) n++;
    end
    check("ign_single", 8'(n), 8'd0);

    // Reset mid-scan while the address is 10.
    in_pat = 4'b1111;
    pulse_start();
    for (int k = 0; k < 4; k++) tick();
    check("mrst_pre_addr", {6'd0, bus.address1, bus.address0}, 8'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_addr",  {6'd0, bus.address1, bus.address0}, 8'd0);
    check("mrst_busy",  {7'd0, bus.busy}, 8'd0);
    check("mrst_valid", {7'd0, bus.frame_valid}, 8'd0);
    check("mrst_frame", {4'd0, bus.frame}, 8'd0);

    // Recovery scan after the mid-scan reset.
    in_pat = 4'b1001;
    pulse_start();
    wait_valid(n);
    check("rec_lat",   8'(n), 8'd8);
    check("rec_frame", {4'd0, bus.frame}, 8'h9);
    consume();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
